// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder.
// FSM state encoding and digit width.
package digit_serial_adder_pkg;

    localparam int DIG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/CLA_4_bits.sv
// 4-bit carry-lookahead adder.
// All carries are computed from generate/propagate in parallel.
module CLA_4_bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one 4-bit CLA step per cycle,
// valid/ready handshake on both operand and result sides.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIG_W;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int MSB  = WIDTH - 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    state_t           state;
    logic [WIDTH-1:0] aop;
    logic [WIDTH-1:0] bop;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf_r;
    logic [IW-1:0]    idx;

    logic [DIG_W-1:0] da;
    logic [DIG_W-1:0] db;
    logic [DIG_W-1:0] ds;
    logic             dc;

    assign da = aop[DIG_W*int'(idx) +: DIG_W];
    assign db = bop[DIG_W*int'(idx) +: DIG_W];

    CLA_4_bits u_cla (
        .a    (da),
        .b    (db),
        .cin  (carry),
        .sum  (ds),
        .cout (dc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            aop   <= '0;
            bop   <= '0;
            res   <= '0;
            carry <= 1'b0;
            ovf_r <= 1'b0;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        aop   <= a;
                        // subtraction is A + ~B + 1
                        bop   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        res   <= '0;
                        ovf_r <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res[DIG_W*int'(idx) +: DIG_W] <= ds;
                    carry <= dc;
                    if (idx == LAST) begin
                        ovf_r <= (aop[MSB] == bop[MSB])
                               && (ds[DIG_W-1] != aop[MSB]);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = res;
    assign cout      = carry;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=16).
// Directed literal cases plus randomized traffic vs an arithmetic model.
module tb_digit_serial_adder;

    localparam int WIDTH = 16;
    localparam int NDIG  = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    bit   pend    = 0;
    bit   seen    = 0;
    bit   hold_prev = 0;
    bit   rand_or = 0;
    exp_t q[$];

    digit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic s);
        exp_t e;
        int   ux, uy, r, sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r   = ux - uy;
            e.c = (ux >= uy);
            sr  = sx - sy;
        end else begin
            r   = ux + uy;
            e.c = (r > 65535);
            sr  = sx + sy;
        end
        e.s = WIDTH'(r);
        e.o = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Per-cycle compare process
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pend      = 0;
            seen      = 0;
            hold_prev = 0;
        end else begin
            chk("in_ready_vs_pending", int'(in_ready),
                int'(q.size() == 0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk("mon_sum", int'(sum), int'(q[0].s));
                    chk("mon_cout", int'(cout), int'(q[0].c));
                    chk("mon_ovf", int'(ovf), int'(q[0].o));
                    if (!seen) begin
                        chk("latency", cyc - acc_cyc, NDIG);
                        seen = 1;
                    end
                end
            end else if (pend && (cyc - acc_cyc > NDIG)) begin
                chk("out_valid_timeout", cyc - acc_cyc, NDIG);
                pend = 0;
            end
            if (hold_prev)
                chk("valid_held_under_stall", int'(out_valid), 1);
            hold_prev = out_valid && !out_ready;
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                pend = 0;
                seen = 0;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub));
                acc_cyc = cyc + 1;
                pend    = 1;
                seen    = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send(input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y,
                        input logic s);
        int  n;
        bit  ok;
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        n  = 0;
        ok = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // scramble the inputs while RUN is in progress
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_done(input string name,
                             input logic [WIDTH-1:0] es,
                             input logic ec,
                             input logic eo);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_sum"}, int'(sum), int'(es));
        chk({name, "_cout"}, int'(cout), int'(ec));
        chk({name, "_ovf"}, int'(ovf), int'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_cout", int'(cout), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(posedge clk);
        #1;

        send(16'h1234, 16'h4321, 1'b0);
        wait_done("add", 16'h5555, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_done("ripple", 16'h0000, 1'b1, 1'b0);
        send(16'h0005, 16'h0007, 1'b1);
        wait_done("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b1);
        wait_done("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_done("add_ovf", 16'h8000, 1'b0, 1'b1);

        // backpressure with a new pair waiting
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        wait_done("bp_first", 16'h3333, 1'b0, 1'b0);
        a        = 16'hAAAA;
        b        = 16'h5555;
        sub      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_in_ready", int'(in_ready), 0);
            chk("bp_hold_sum", int'(sum), 16'h3333);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'hAAAA, 16'h5555, 1'b0);
        wait_done("bp_second", 16'hFFFF, 1'b0, 1'b0);

        // reset after two RUN cycles
        send(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_in_ready", int'(in_ready), 1);
        chk("midrun_out_valid", int'(out_valid), 0);
        chk("midrun_sum", int'(sum), 0);
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0);
        wait_done("post_rst", 16'h0002, 1'b0, 1'b0);

        // randomized traffic with random result stalls
        rand_or = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_idle();
            @(posedge clk);
            #1;
        end
        rand_or = 0;
        #1;
        out_ready = 1'b1;
        repeat (NDIG + 3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
